// File: rtl/mii_rx_decoder_if.sv
// MII receive-side bundle: PHY nibble stream into the decoder, byte stream
// and frame statistics out of it.
interface mii_rx_decoder_if;
  logic [3:0]  i_rx_d;
  logic        i_rx_dv;
  logic        i_rx_er;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_last;
  logic        o_error;
  logic        o_frame_drop;
  logic [15:0] o_good_frames;
  logic [15:0] o_bad_frames;

  modport master (
    output i_rx_d, i_rx_dv, i_rx_er,
    input  o_data, o_valid, o_last, o_error, o_frame_drop,
           o_good_frames, o_bad_frames
  );

  modport slave (
    input  i_rx_d, i_rx_dv, i_rx_er,
    output o_data, o_valid, o_last, o_error, o_frame_drop,
           o_good_frames, o_bad_frames
  );
endinterface

// File: rtl/mii_rx_decoder.sv
// MII receive decoder: strips preamble/SFD, assembles bytes, checks FCS and
// length, and streams DA..last payload byte with FCS removed.
module mii_rx_decoder #(
  parameter int p_MIN_FRAME_BYTES = 64,
  parameter int p_MAX_FRAME_BYTES = 1518
) (
  input logic            i_clk,
  input logic            i_reset_n,
  mii_rx_decoder_if.slave bus
);

  localparam int unsigned CW = $clog2(p_MAX_FRAME_BYTES + 2);
  localparam logic [CW-1:0] MIN_C  = CW'(p_MIN_FRAME_BYTES);
  localparam logic [CW-1:0] MAX_C  = CW'(p_MAX_FRAME_BYTES);
  localparam logic [CW-1:0] SAT_C  = CW'(p_MAX_FRAME_BYTES + 1);
  localparam logic [CW-1:0] LINE_C = CW'(4);
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    ST_DROP,
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA
  } state_t;

  state_t          state_q, state_d;
  logic            phase_q, phase_d;
  logic [3:0]      nib_q, nib_d;
  logic [31:0]     crc_q, crc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0][7:0] dly_q, dly_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_vld_q, hold_vld_d;
  logic            rxer_q, rxer_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            error_q, error_d;
  logic            drop_q, drop_d;
  logic [15:0]     good_q, good_d;
  logic [15:0]     bad_q, bad_d;

  logic [7:0]      new_byte;
  logic            frame_bad;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign new_byte  = {bus.i_rx_d, nib_q};
  assign frame_bad = (crc_q != CRC_RESIDUE) || rxer_q || phase_q ||
                     (cnt_q < MIN_C) || (cnt_q > MAX_C);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    nib_d      = nib_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    dly_d      = dly_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    rxer_d     = rxer_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    error_d    = 1'b0;
    drop_d     = 1'b0;
    good_d     = good_q;
    bad_d      = bad_q;

    unique case (state_q)
      ST_DROP: begin
        if (!bus.i_rx_dv) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (bus.i_rx_dv) begin
          state_d = (bus.i_rx_d == 4'h5) ? ST_PREAMBLE : ST_DROP;
        end
      end

      ST_PREAMBLE: begin
        if (!bus.i_rx_dv) begin
          state_d = ST_IDLE;
        end else if (bus.i_rx_er) begin
          state_d = ST_DROP;
        end else if (bus.i_rx_d == 4'hD) begin
          state_d    = ST_DATA;
          phase_d    = 1'b0;
          crc_d      = '1;
          cnt_d      = '0;
          hold_vld_d = 1'b0;
          rxer_d     = 1'b0;
        end else if (bus.i_rx_d != 4'h5) begin
          state_d = ST_DROP;
        end
      end

      ST_DATA: begin
        if (!bus.i_rx_dv) begin
          state_d = ST_IDLE;
          if (hold_vld_q) begin
            data_d  = hold_q;
            valid_d = 1'b1;
            last_d  = 1'b1;
            error_d = frame_bad;
            if (frame_bad) bad_d  = bad_q + 16'd1;
            else           good_d = good_q + 16'd1;
          end else begin
            drop_d = 1'b1;
            bad_d  = bad_q + 16'd1;
          end
        end else begin
          if (bus.i_rx_er) rxer_d = 1'b1;
          if (!phase_q) begin
            nib_d   = bus.i_rx_d;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            crc_d   = crc32_byte(crc_q, new_byte);
            if (cnt_q != SAT_C) cnt_d = cnt_q + CW'(1);
            dly_d = {dly_q[2:0], new_byte};
            // Once the delay line is primed, each new byte pushes the oldest
            // into the hold register, which releases its previous occupant.
            if (cnt_q >= LINE_C) begin
              hold_d     = dly_q[3];
              hold_vld_d = 1'b1;
              if (hold_vld_q) begin
                data_d  = hold_q;
                valid_d = 1'b1;
              end
            end
          end
        end
      end

      default: state_d = ST_DROP;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_DROP;
      phase_q    <= 1'b0;
      nib_q      <= '0;
      crc_q      <= '0;
      cnt_q      <= '0;
      dly_q      <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      rxer_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      error_q    <= 1'b0;
      drop_q     <= 1'b0;
      good_q     <= '0;
      bad_q      <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      nib_q      <= nib_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      dly_q      <= dly_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      rxer_q     <= rxer_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      error_q    <= error_d;
      drop_q     <= drop_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
    end
  end

  assign bus.o_data        = data_q;
  assign bus.o_valid       = valid_q;
  assign bus.o_last        = last_q;
  assign bus.o_error       = error_q;
  assign bus.o_frame_drop  = drop_q;
  assign bus.o_good_frames = good_q;
  assign bus.o_bad_frames  = bad_q;

endmodule

// File: tb/tb_mii_rx_decoder.sv
// Directed bench for mii_rx_decoder: frames are queued on a scoreboard as they
// are driven and checked byte by byte as the decoder emits them.
module tb_mii_rx_decoder;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mii_rx_decoder_if bus();

  mii_rx_decoder #(
    .p_MIN_FRAME_BYTES(64),
    .p_MAX_FRAME_BYTES(1518)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  always #20 clk = ~clk;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  frm[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned drops_seen = 0;
  int unsigned drops_exp = 0;
  logic [15:0] exp_good = '0;
  logic [15:0] exp_bad = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every o_valid byte must match the head of the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.o_frame_drop === 1'b1) drops_seen++;
      if (bus.o_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", {31'b0, bus.o_valid}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("data", {24'b0, bus.o_data}, {24'b0, mon_e.data});
          check("last", {31'b0, bus.o_last}, {31'b0, mon_e.last});
          if (mon_e.last) check("error", {31'b0, bus.o_error}, {31'b0, mon_e.err});
        end
      end
    end
  end

  task automatic drive(input logic [3:0] nib, input logic dv, input logic er);
    @(negedge clk);
    bus.i_rx_d  = nib;
    bus.i_rx_dv = dv;
    bus.i_rx_er = er;
  endtask

  task automatic build_arp();
    logic [7:0] hdr [42] = '{
      8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
      8'h08, 8'h00, 8'h27, 8'hE9, 8'h5E, 8'h81,
      8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
      8'h08, 8'h00, 8'h27, 8'hE9, 8'h5E, 8'h81, 8'hC0, 8'hA8, 8'h01, 8'h64,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h01};
    frm.delete();
    for (int i = 0; i < 42; i++) frm.push_back(hdr[i]);
    while (frm.size() < 60) frm.push_back(8'h00);
  endtask

  task automatic build_seq(input int n, input logic [7:0] seed);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(seed + 8'(i));
  endtask

  // Standard Ethernet FCS: reflected CRC-32, inverted, sent LSB byte first.
  task automatic add_fcs();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < frm.size(); i++) begin
      c = c ^ {24'h0, frm[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  task automatic send_frame(input bit pre_bad, input int flip_byte, input int er_nib,
                            input int rst_byte, input bit exp_err, input int idle);
    int         n;
    logic [7:0] b;
    bit         counted;
    n = frm.size();
    counted = !pre_bad && (rst_byte < 0);
    if (flip_byte >= 0) frm[flip_byte] = frm[flip_byte] ^ 8'h04;
    if (counted) begin
      if (n >= 5) begin
        for (int i = 0; i < n - 4; i++) sb.push_back('{frm[i], (i == n - 5), exp_err});
      end else begin
        drops_exp++;
      end
    end
    for (int i = 0; i < 15; i++) drive((pre_bad && i == 3) ? 4'h7 : 4'h5, 1'b1, 1'b0);
    drive(4'hD, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == rst_byte) begin
        rst_n    = 1'b0;
        exp_good = '0;
        exp_bad  = '0;
      end
      if (rst_byte >= 0 && i == rst_byte + 2) rst_n = 1'b1;
      b = frm[i];
      drive(b[3:0], 1'b1, (2 * i) == er_nib);
      drive(b[7:4], 1'b1, (2 * i + 1) == er_nib);
    end
    for (int i = 0; i < idle; i++) drive(4'h0, 1'b0, 1'b0);
    if (counted) begin
      if (n < 5 || exp_err) exp_bad = exp_bad + 16'd1;
      else                  exp_good = exp_good + 16'd1;
    end
  endtask

  task automatic check_counts(input string tag);
    @(posedge clk);
    #2;
    check({tag, "_good"}, {16'b0, bus.o_good_frames}, {16'b0, exp_good});
    check({tag, "_bad"}, {16'b0, bus.o_bad_frames}, {16'b0, exp_bad});
    check({tag, "_drops"}, drops_seen, drops_exp);
    check({tag, "_pending"}, sb.size(), 32'd0);
  endtask

  initial begin
    bus.i_rx_d  = 4'h0;
    bus.i_rx_dv = 1'b0;
    bus.i_rx_er = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", {24'b0, bus.o_data}, 32'd0);
    check("rst_valid", {31'b0, bus.o_valid}, 32'd0);
    check("rst_last", {31'b0, bus.o_last}, 32'd0);
    check("rst_error", {31'b0, bus.o_error}, 32'd0);
    check("rst_drop", {31'b0, bus.o_frame_drop}, 32'd0);
    check("rst_good", {16'b0, bus.o_good_frames}, 32'd0);
    check("rst_bad", {16'b0, bus.o_bad_frames}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) drive(4'h0, 1'b0, 1'b0);

    build_arp(); add_fcs();
    send_frame(1'b0, -1, -1, -1, 1'b0, 3);
    check_counts("arp_good");

    build_arp(); add_fcs();
    send_frame(1'b0, 20, -1, -1, 1'b1, 3);
    check_counts("arp_corrupt");

    build_arp(); add_fcs();
    send_frame(1'b0, -1, 61, -1, 1'b1, 3);
    check_counts("arp_rx_er");

    build_seq(16, 8'h30); add_fcs();
    send_frame(1'b0, -1, -1, -1, 1'b1, 3);
    check_counts("runt");

    build_seq(3, 8'hA0);
    send_frame(1'b0, -1, -1, -1, 1'b0, 3);
    check_counts("short_drop");

    build_arp(); add_fcs();
    send_frame(1'b1, -1, -1, -1, 1'b0, 3);
    check_counts("bad_preamble");

    build_seq(1514, 8'h11); add_fcs();
    send_frame(1'b0, -1, -1, -1, 1'b0, 3);
    check_counts("max_len");

    build_seq(1515, 8'h22); add_fcs();
    send_frame(1'b0, -1, -1, -1, 1'b1, 3);
    check_counts("oversize");

    build_arp(); add_fcs();
    send_frame(1'b0, -1, -1, 4, 1'b0, 3);
    check_counts("reset_mid");

    build_arp(); add_fcs();
    send_frame(1'b0, -1, -1, -1, 1'b0, 3);
    check_counts("after_reset");

    build_arp(); add_fcs();
    send_frame(1'b0, -1, -1, -1, 1'b0, 1);
    build_seq(70, 8'h5A); add_fcs();
    send_frame(1'b0, -1, -1, -1, 1'b0, 3);
    check_counts("back_to_back");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mii_rx_decoder.md
MII_RX_DECODER -- requirements
Module: mii_rx_decoder

Interface
REQ-001 Parameter p_MIN_FRAME_BYTES, default 64, minimum legal frame length in bytes (DA through FCS inclusive).
REQ-002 Parameter p_MAX_FRAME_BYTES, default 1518, maximum legal frame length in bytes (DA through FCS inclusive).
REQ-003 Port i_clk, input, 1, MII receive clock (25 MHz); the block has one clock.
REQ-004 Port i_reset_n, input, 1, reset; asynchronous, active-low.
REQ-005 Port i_rx_d, input, 4, MII receive nibble.
REQ-006 Port i_rx_dv, input, 1, MII receive data valid.
REQ-007 Port i_rx_er, input, 1, MII receive error.
REQ-008 Port o_data, output, 8, payload byte (DA through last byte before FCS).
REQ-009 Port o_valid, output, 1, o_data is valid this cycle; no backpressure.
REQ-010 Port o_last, output, 1, the current o_data byte is the final byte of the frame.
REQ-011 Port o_error, output, 1, frame is bad; valid only together with o_last.
REQ-012 Port o_frame_drop, output, 1, one-cycle pulse when a frame is discarded with no bytes emitted.
REQ-013 Port o_good_frames, output, 16, count of frames ending with o_last=1 and o_error=0; wraps at 0xFFFF.
REQ-014 Port o_bad_frames, output, 16, count of frames ending with o_error=1 plus o_frame_drop pulses; wraps at 0xFFFF.

Function
REQ-015 All inputs are sampled on the rising edge of i_clk; all outputs are registered.
REQ-016 The state machine has four states: DROP, IDLE, PREAMBLE and DATA.
REQ-017 DROP: the block waits for i_rx_dv=0, then moves to IDLE.
REQ-018 IDLE: i_rx_dv=1 with i_rx_d=0x5 moves to PREAMBLE; i_rx_dv=1 with any other nibble moves to DROP with no pulse.
REQ-019 PREAMBLE: nibble 0x5 stays in PREAMBLE; nibble 0xD moves to DATA with the nibble phase cleared.
REQ-020 PREAMBLE: any other nibble, or i_rx_er=1, moves to DROP; i_rx_dv=0 moves to IDLE; neither case produces an o_frame_drop pulse.
REQ-021 DATA: nibbles are assembled low nibble first, so byte = {second nibble, first nibble}.
REQ-022 DATA: each completed byte updates the CRC-32 (reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, no final XOR) and the byte counter.
REQ-023 DATA: the byte counter saturates at p_MAX_FRAME_BYTES+1.
REQ-024 DATA: completed bytes enter a 4-byte delay line.
REQ-025 DATA: the byte leaving the delay line loads a one-byte hold register.
REQ-026 DATA: when the hold register is already full at that load, its previous byte is presented on o_data with o_valid=1 and o_last=0.
REQ-027 Latency: byte k (0-based after the SFD) appears on o_data one cycle after byte k+5 completes.
REQ-028 End of frame: i_rx_dv=0 in DATA ends the frame.
REQ-029 End of frame, hold register full: the held byte is presented with o_valid=1 and o_last=1, and the state returns to IDLE.
REQ-030 End of frame, hold register empty (fewer than 5 bytes received): o_frame_drop pulses for one cycle and nothing is emitted.
REQ-031 o_error=1 at o_last if the CRC register is not 0xDEBB20E3.
REQ-032 o_error=1 at o_last if i_rx_er was seen at any point in DATA.
REQ-033 o_error=1 at o_last if an odd nibble count was received (the partial nibble is discarded).
REQ-034 o_error=1 at o_last if the byte count is < p_MIN_FRAME_BYTES or > p_MAX_FRAME_BYTES.
REQ-035 Oversize frames continue streaming to their end; they are not truncated.
REQ-036 o_good_frames or o_bad_frames increments in the same cycle as o_last, or as o_frame_drop for o_bad_frames.
REQ-037 Back-to-back frames need no extra IDLE cycles beyond one cycle with i_rx_dv=0.

Reset
REQ-038 On i_reset_n=0, state=DROP.
REQ-039 On i_reset_n=0, o_data=0, o_valid=0, o_last=0, o_error=0 and o_frame_drop=0.
REQ-040 On i_reset_n=0, both counters, the CRC register, the delay line, the hold register and the phase register are cleared.
REQ-041 A frame in progress at reset release is ignored entirely because the block starts in DROP.

Verification
REQ-042 7x55, D5, then 60-byte ARP request (FF FF FF FF FF FF 08 00 27 E9 5E 81 08 06 ... 00) and FCS E8 F1 6B F3 -> 60 o_valid bytes, first FF, last 00 with o_last=1, o_error=0; o_good_frames=1.
REQ-043 Same frame with one payload nibble corrupted -> 60 bytes, o_last=1, o_error=1; o_bad_frames=1.
REQ-044 Same frame with i_rx_er=1 for one cycle mid-payload -> o_error=1; a 20-byte frame with valid FCS -> o_error=1 (runt).
REQ-045 i_rx_dv high for only 3 bytes after SFD -> one o_frame_drop pulse, o_valid never asserted; a preamble containing 0x7 -> no output and no pulse.
REQ-046 Reset asserted mid-frame, released while i_rx_dv=1 -> no output until i_rx_dv falls; the next frame decodes good.
REQ-047 Two good frames separated by one idle cycle -> two o_last pulses, o_good_frames=2.
